// File: rtl/ui_pkg.sv
// Shared definitions for the user-interface blocks (button input, LED output).
package ui_pkg;

  // Blink driver FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_e;

  // Board clock and derived millisecond tick count
  localparam int unsigned CLK_HZ        = 12000000;
  localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

  // Larger of two unsigned values, usable in constant expressions
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter that parks at zero and flags it.
module interval_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over counting; zero is registered together with the count
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (count != '0) begin
      count <= count - W'(1);
      zero  <= (count == W'(1));
    end
  end

endmodule

// File: rtl/led_blink_driver.sv
// Turns single-cycle request ticks into queued, back-to-back LED blinks.
module led_blink_driver
  import ui_pkg::*;
#(
  parameter int unsigned ON_CYCLES   = 1200000,
  parameter int unsigned OFF_CYCLES  = 1200000,
  parameter int unsigned MAX_PENDING = 7,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_tick,
  output logic                               led_out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned TMR_W  = max_u(1, $clog2(max_u(ON_CYCLES, OFF_CYCLES)));

  localparam logic LED_ACTIVE   = !ACTIVE_LOW;
  localparam logic LED_INACTIVE = ACTIVE_LOW;

  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
  localparam logic [TMR_W-1:0]  ON_LOAD   = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  OFF_LOAD  = TMR_W'(OFF_CYCLES - 1);

  blink_state_e      state;
  logic              t_zero;
  logic              start_c;
  logic              to_off_c;
  logic              t_load_c;
  logic [TMR_W-1:0]  t_val_c;

  // A blink starts from IDLE, or straight out of an expired OFF gap
  always_comb begin
    start_c  = 1'b0;
    to_off_c = 1'b0;
    if (pending != '0) begin
      start_c = (state == IDLE) || ((state == OFF) && t_zero);
    end
    to_off_c = (state == ON) && t_zero;
    t_load_c = start_c || to_off_c;
    t_val_c  = start_c ? ON_LOAD : OFF_LOAD;
  end

  interval_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load_c),
    .load_val (t_val_c),
    .zero     (t_zero)
  );

  // Phase sequencing, request queue and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      led_out  <= LED_INACTIVE;
    end else begin
      overflow <= 1'b0;
      // Simultaneous request and blink start cancel out, even when full
      if (req_tick && !start_c) begin
        if (pending < PEND_MAX) begin
          pending <= pending + PEND_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end else if (!req_tick && start_c) begin
        pending <= pending - PEND_W'(1);
      end

      case (state)
        IDLE: begin
          if (start_c) begin
            state   <= ON;
            busy    <= 1'b1;
            led_out <= LED_ACTIVE;
          end
        end
        ON: begin
          if (t_zero) begin
            state   <= OFF;
            led_out <= LED_INACTIVE;
          end
        end
        OFF: begin
          if (t_zero) begin
            if (start_c) begin
              state   <= ON;
              led_out <= LED_ACTIVE;
            end else begin
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          led_out <= LED_INACTIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed-vector bench for led_blink_driver with short blink timings.
module tb_led_blink_driver;

  localparam int unsigned ON_C   = 4;
  localparam int unsigned OFF_C  = 3;
  localparam int unsigned MAXP   = 3;
  localparam int unsigned PEND_W = $clog2(MAXP + 1);

  logic              clk;
  logic              rst;
  logic              req_tick;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  int unsigned n_checks;
  int unsigned n_fails;
  int unsigned cyc;
  string       phase;

  led_blink_driver #(
    .ON_CYCLES   (ON_C),
    .OFF_CYCLES  (OFF_C),
    .MAX_PENDING (MAXP),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_tick (req_tick),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s @%s cycle %0d: got %0d, expected %0d", tag, phase, cyc, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then compare all outputs just after it
  task automatic vec(input logic r_req, input logic r_rst, input logic e_led,
                     input logic e_busy, input int unsigned e_pend, input logic e_ovf);
    req_tick = r_req;
    rst      = r_rst;
    @(posedge clk);
    #1;
    cyc++;
    check("led_out",  32'(led_out),  32'(e_led));
    check("busy",     32'(busy),     32'(e_busy));
    check("pending",  32'(pending),  e_pend);
    check("overflow", 32'(overflow), 32'(e_ovf));
  endtask

  // One full blink with no new requests: 4 cycles LED low, 3 cycles high
  task automatic blink(input int unsigned p);
    repeat (ON_C)  vec(1'b0, 1'b0, 1'b0, 1'b1, p, 1'b0);
    repeat (OFF_C) vec(1'b0, 1'b0, 1'b1, 1'b1, p, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    cyc      = 0;
    rst      = 1'b1;
    req_tick = 1'b0;

    // Reset holds everything quiet even with requests present
    phase = "reset";
    repeat (3) vec(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    repeat (3) vec(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Single request: one cycle queued, then one full blink
    phase = "single"; cyc = 0;
    vec(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    blink(0);
    vec(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Three back-to-back requests: three blinks with no idle gap
    phase = "triple"; cyc = 0;
    vec(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    repeat (2) vec(1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    repeat (3) vec(1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    blink(1);
    blink(0);
    vec(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Queue saturation: the 4th and 5th requests after the first are dropped
    phase = "overflow"; cyc = 0;
    vec(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    vec(1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    repeat (2) vec(1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    blink(2);
    blink(1);
    blink(0);
    repeat (3) vec(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Request on the OFF-to-ON edge with a full queue: no change, no overflow
    phase = "simul"; cyc = 0;
    vec(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    repeat (3) vec(1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    repeat (3) vec(1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    repeat (3) vec(1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);

    // Reset mid-ON with two queued: everything clears, nothing resumes
    phase = "midreset"; cyc = 0;
    vec(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    repeat (12) vec(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
